dcache_miss_ctrl: RTL and testbench
===================================

// Module: dcache_miss_ctrl
// PURPOSE
//   Data-cache miss controller for the MEM stage. Watches the EX/MEM access (memRead/memWrite)
//   plus the tag-compare result. On a miss it stalls the whole pipeline, including the EX/MEM
//   register stall_i, and writes back a dirty victim line. It then allocates the requested line
//   over a req/ack off-chip memory port and fills the cache. Write-allocate, write-back policy.
// PARAMETERS
//   ADDR_W    32  byte-address width
//   OFFSET_W  5   line-offset bits (32-byte line)
//   INDEX_W   5   set-index bits (direct-mapped, 32 lines)
//   CNT_W     32  width of the performance counters
// PORTS
//   clk_i        in   1                     clock, rising edge
//   rst_i        in   1                     asynchronous reset, active-low
//   memRead_i    in   1                     load in MEM stage (from EX/MEM)
//   memWrite_i   in   1                     store in MEM stage (from EX/MEM)
//   addr_i       in   ADDR_W                access byte address (EX/MEM aluResult)
//   hit_i        in   1                     tag match and valid for addr_i, combinational from tag RAM
//   dirty_i      in   1                     indexed line is valid and dirty
//   victimTag_i  in   ADDR_W-OFFSET_W-INDEX_W   tag stored at indexed line
//   stall_o      out  1                     freeze PC, IF/ID, ID/EX, EX/MEM, MEM/WB
//   memReq_o     out  1                     off-chip request
//   memWe_o      out  1                     1 = line write-back, 0 = line read
//   memAddr_o    out  ADDR_W                line-aligned address, offset bits zero
//   memAck_i     in   1                     one-cycle ack; read data valid same cycle
//   cacheFill_o  out  1                     write fetched line into data/tag RAM, set valid, clear dirty
//   missCnt_o    out  CNT_W                 misses taken, saturating
//   stallCnt_o   out  CNT_W                 cycles with stall_o=1, saturating
// BEHAVIOUR
//   - Reset (rst_i=0, async): state=IDLE; memReq_o=0; memWe_o=0; memAddr_o=0; cacheFill_o=0;
//     counters=0; captured address=0. Reset mid-transaction abandons the request.
//   - access = memRead_i | memWrite_i. miss = access & ~hit_i.
//   - stall_o = (state!=IDLE) | (state==IDLE & miss). Combinational, so EX/MEM holds in the
//     same cycle the miss is seen.
//   - States:
//     IDLE:  miss & dirty_i -> WB; miss & ~dirty_i -> ALLOC. On leaving IDLE, latch
//            addr_i (tag, index) and victimTag_i; missCnt_o += 1.
//            Hit or no access: stay, no stall.
//     WB:    memReq_o=1, memWe_o=1, memAddr_o={victimTag,index,0}. On memAck_i -> ALLOC.
//     ALLOC: memReq_o=1, memWe_o=0, memAddr_o={tag,index,0}. On memAck_i -> FILL.
//     FILL:  cacheFill_o=1 for exactly one cycle, stall_o=1. -> IDLE unconditionally.
//   - After FILL, IDLE re-evaluates with a now-hitting line and stall drops. A store then writes
//     the cache, which sets dirty; that update lives outside this block.
//   - Request signals are registered outputs and stay stable until ack. memReq_o deasserts
//     the cycle after ack.
//   - memAck_i is ignored in IDLE and FILL.
//   - Latency (miss cycle = cycle 0, memory acks N cycles after req rises):
//     clean miss stall = N+3 cycles; dirty miss adds N+1.
//   - Counters saturate at all-ones and never wrap.
//   - stallCnt_o increments every cycle stall_o=1, including the combinational IDLE miss cycle.
//   - Miss on both read and write asserted together is treated as one access.
//   - Latched address is used after IDLE. addr_i changes while stalled have no effect.
// STRUCTURE
//   - Shared package dcache_pkg: state encoding (IDLE, WB, ALLOC, FILL, 2-bit);
//     TAG_W = ADDR_W-OFFSET_W-INDEX_W; a line-address helper {tag,index,zeros}.
//   - One sub-module, sat_counter (param WIDTH; inc, clk, async active-low rst), instanced
//     twice for missCnt_o and stallCnt_o.
//   - FSM next-state and output decode in the main module. Request outputs are registered.
// TESTING
//   1. Read hit: memRead=1, hit=1 for 10 cycles -> stall_o=0 throughout, memReq_o=0,
//      counters stay 0.
//   2. Clean read miss at 0x0000_1234, ack after 4 cycles -> memAddr_o=0x0000_1220, memWe_o=0,
//      one cacheFill_o pulse, stall held 7 cycles, missCnt_o=1, stallCnt_o=7.
//   3. Dirty write miss, addr 0x0000_2040, victimTag forming 0x0000_8040 -> WB to 0x0000_8040
//      with memWe_o=1, then ALLOC 0x0000_2040 with memWe_o=0, then FILL.
//   4. Spurious memAck_i in IDLE and during FILL -> no state change, no memReq_o.
//   5. rst_i low during ALLOC -> memReq_o, stall_o and cacheFill_o drop immediately, counters 0.
//      After release, a hit proceeds without stall.
//   6. Preload counters near all-ones (force CNT_W=4 build) and run 20 misses -> both
//      counters hold at 15.

Source files
------------

// File: rtl/dcache_pkg.sv
// Shared data-cache definitions: default geometry, miss FSM state encoding, line-address helper.
package dcache_pkg;
  localparam int DC_ADDR_W   = 32;
  localparam int DC_OFFSET_W = 5;
  localparam int DC_INDEX_W  = 5;
  localparam int TAG_W       = DC_ADDR_W - DC_OFFSET_W - DC_INDEX_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WB    = 2'd1,
    ALLOC = 2'd2,
    FILL  = 2'd3
  } missState_e;

  function automatic logic [DC_ADDR_W-1:0] lineAddr(input logic [TAG_W-1:0] tag,
                                                    input logic [DC_INDEX_W-1:0] index);
    return {tag, index, {DC_OFFSET_W{1'b0}}};
  endfunction
endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc,
  output logic [WIDTH-1:0] cnt
);
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)              cnt <= '0;
    else if (inc && ~&cnt)   cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/dcache_miss_ctrl.sv
// MEM-stage data-cache miss controller: stalls the pipeline, writes back a dirty victim,
// fetches the missing line over a req/ack port and pulses a cache fill.
module dcache_miss_ctrl import dcache_pkg::*; #(
  parameter int ADDR_W   = DC_ADDR_W,
  parameter int OFFSET_W = DC_OFFSET_W,
  parameter int INDEX_W  = DC_INDEX_W,
  parameter int CNT_W    = 32
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            memRead_i,
  input  logic                            memWrite_i,
  input  logic [ADDR_W-1:0]               addr_i,
  input  logic                            hit_i,
  input  logic                            dirty_i,
  input  logic [ADDR_W-OFFSET_W-INDEX_W-1:0] victimTag_i,
  output logic                            stall_o,
  output logic                            memReq_o,
  output logic                            memWe_o,
  output logic [ADDR_W-1:0]               memAddr_o,
  input  logic                            memAck_i,
  output logic                            cacheFill_o,
  output logic [CNT_W-1:0]                missCnt_o,
  output logic [CNT_W-1:0]                stallCnt_o
);
  localparam int TW = ADDR_W - OFFSET_W - INDEX_W;

  missState_e          state, stateNext;
  logic [TW-1:0]       tagQ, victimQ, tagSel, victimSel;
  logic [INDEX_W-1:0]  idxQ, idxSel;
  logic                miss, missTaken;
  logic                memReqNext, memWeNext;
  logic [ADDR_W-1:0]   memAddrNext;

  assign miss      = (memRead_i | memWrite_i) & ~hit_i;
  assign missTaken = (state == IDLE) & miss;
  assign stall_o   = (state != IDLE) | missTaken;
  assign cacheFill_o = (state == FILL);

  // On the cycle we leave IDLE the latches are not loaded yet, so take the live inputs.
  assign tagSel    = (state == IDLE) ? addr_i[ADDR_W-1 -: TW]      : tagQ;
  assign idxSel    = (state == IDLE) ? addr_i[OFFSET_W +: INDEX_W] : idxQ;
  assign victimSel = (state == IDLE) ? victimTag_i                 : victimQ;

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (miss) stateNext = dirty_i ? WB : ALLOC;
      WB:      if (memAck_i) stateNext = ALLOC;
      ALLOC:   if (memAck_i) stateNext = FILL;
      FILL:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Request outputs are decoded from the next state so they register in with it.
  always_comb begin
    memReqNext  = (stateNext == WB) || (stateNext == ALLOC);
    memWeNext   = (stateNext == WB);
    memAddrNext = '0;
    if (stateNext == WB)         memAddrNext = {victimSel, idxSel, {OFFSET_W{1'b0}}};
    else if (stateNext == ALLOC) memAddrNext = {tagSel, idxSel, {OFFSET_W{1'b0}}};
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state     <= IDLE;
      memReq_o  <= 1'b0;
      memWe_o   <= 1'b0;
      memAddr_o <= '0;
      tagQ      <= '0;
      idxQ      <= '0;
      victimQ   <= '0;
    end else begin
      state     <= stateNext;
      memReq_o  <= memReqNext;
      memWe_o   <= memWeNext;
      memAddr_o <= memAddrNext;
      if (missTaken) begin
        tagQ    <= addr_i[ADDR_W-1 -: TW];
        idxQ    <= addr_i[OFFSET_W +: INDEX_W];
        victimQ <= victimTag_i;
      end
    end
  end

  sat_counter #(.WIDTH(CNT_W)) uMissCnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc   (missTaken),
    .cnt   (missCnt_o)
  );

  sat_counter #(.WIDTH(CNT_W)) uStallCnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc   (stall_o),
    .cnt   (stallCnt_o)
  );
endmodule

// File: tb/tb_dcache_miss_ctrl.sv
// Directed bench for dcache_miss_ctrl; a 4-bit-counter copy shares the stimulus for saturation.
module tb_dcache_miss_ctrl;
  logic        clk = 1'b0;
  logic        rstN;
  logic        memRead, memWrite, hit, dirty, memAck;
  logic [31:0] addr;
  logic [21:0] victimTag;

  logic        stall, memReq, memWe, fill;
  logic [31:0] memAddr, missCnt, stallCnt;
  logic        stall4, memReq4, memWe4, fill4;
  logic [31:0] memAddr4;
  logic [3:0]  missCnt4, stallCnt4;

  int totalNum = 0;
  int badNum   = 0;

  always #5 clk = ~clk;

  dcache_miss_ctrl #(.CNT_W(32)) dut (
    .clk_i(clk), .rst_i(rstN), .memRead_i(memRead), .memWrite_i(memWrite), .addr_i(addr),
    .hit_i(hit), .dirty_i(dirty), .victimTag_i(victimTag), .stall_o(stall), .memReq_o(memReq),
    .memWe_o(memWe), .memAddr_o(memAddr), .memAck_i(memAck), .cacheFill_o(fill),
    .missCnt_o(missCnt), .stallCnt_o(stallCnt)
  );

  dcache_miss_ctrl #(.CNT_W(4)) dut4 (
    .clk_i(clk), .rst_i(rstN), .memRead_i(memRead), .memWrite_i(memWrite), .addr_i(addr),
    .hit_i(hit), .dirty_i(dirty), .victimTag_i(victimTag), .stall_o(stall4), .memReq_o(memReq4),
    .memWe_o(memWe4), .memAddr_o(memAddr4), .memAck_i(memAck), .cacheFill_o(fill4),
    .missCnt_o(missCnt4), .stallCnt_o(stallCnt4)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    totalNum++;
    if (got !== exp) begin
      badNum++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // One miss transaction; memory acks n cycles after each request phase begins.
  // Called just after a rising edge; returns just after a rising edge.
  task automatic missTxn(input logic [31:0] a, input logic [1:0] rw, input logic d,
                         input logic [21:0] vt, input int n, input logic ackExtra,
                         output int stalls, output int fills, output logic [31:0] wbA,
                         output logic [31:0] alA, output int reqInFill);
    int       age;
    logic [1:0] ph, phPrev;
    logic     done, gotWb, gotAl, realAck, prevReal;
    stalls = 0; fills = 0; wbA = '0; alA = '0; reqInFill = 0;
    age = 0; phPrev = 2'b00; done = 1'b0; gotWb = 1'b0; gotAl = 1'b0; prevReal = 1'b0;
    memRead = rw[0]; memWrite = rw[1]; addr = a; hit = 1'b0; dirty = d; victimTag = vt;
    memAck = 1'b0;
    for (int c = 0; c < 200 && !done; c++) begin
      if (c > 0) begin
        addr = 32'hDEAD_BEEF;
        victimTag = 22'h155555;
        ph = {memReq, memWe};
        if (ph != phPrev) age = 0; else age++;
        phPrev = ph;
        realAck = memReq && (age == n);
        memAck = realAck || (ackExtra && prevReal);
        prevReal = realAck;
      end
      @(negedge clk);
      if (stall) stalls++; else done = 1'b1;
      if (fill) begin
        fills++;
        if (memReq) reqInFill++;
        hit = 1'b1;
      end
      if (memReq && memWe && !gotWb)  begin wbA = memAddr; gotWb = 1'b1; end
      if (memReq && !memWe && !gotAl) begin alA = memAddr; gotAl = 1'b1; end
      step();
    end
    chk("txnDone", done, 1);
    memRead = 1'b0; memWrite = 1'b0; memAck = 1'b0; hit = 1'b0; dirty = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int st, fl, rf;
    logic [31:0] wa, aa;
    rstN = 1'b0; memRead = 0; memWrite = 0; hit = 0; dirty = 0; memAck = 0;
    addr = '0; victimTag = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rstStall", stall, 0);
    chk("rstReq", memReq, 0);
    chk("rstWe", memWe, 0);
    chk("rstAddr", memAddr, 0);
    chk("rstFill", fill, 0);
    chk("rstMissCnt", missCnt, 0);
    chk("rstStallCnt", stallCnt, 0);
    step();
    rstN = 1'b1;
    step();

    // 1: read hits never stall
    memRead = 1; hit = 1; addr = 32'h0000_0100;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hitStall", stall, 0);
      chk("hitReq", memReq, 0);
      step();
    end
    memRead = 0; hit = 0;
    chk("hitMissCnt", missCnt, 0);
    chk("hitStallCnt", stallCnt, 0);

    // 2: clean read miss, ack 4 cycles after request
    missTxn(32'h0000_1234, 2'b01, 1'b0, 22'h0, 4, 1'b0, st, fl, wa, aa, rf);
    chk("cleanStalls", st, 7);
    chk("cleanFills", fl, 1);
    chk("cleanAllocAddr", aa, 32'h0000_1220);
    chk("cleanNoWb", wa, 0);
    chk("cleanReqInFill", rf, 0);
    chk("cleanMissCnt", missCnt, 1);
    chk("cleanStallCnt", stallCnt, 7);

    // 3: dirty write miss, victim line 0x8040
    missTxn(32'h0000_2040, 2'b10, 1'b1, 22'h20, 2, 1'b0, st, fl, wa, aa, rf);
    chk("dirtyStalls", st, 8);
    chk("dirtyFills", fl, 1);
    chk("dirtyWbAddr", wa, 32'h0000_8040);
    chk("dirtyAllocAddr", aa, 32'h0000_2040);
    chk("dirtyMissCnt", missCnt, 2);
    chk("dirtyStallCnt", stallCnt, 15);

    // 4: stray acks in IDLE, then an ack held into FILL on a read+write miss
    memAck = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("idleAckReq", memReq, 0);
      chk("idleAckStall", stall, 0);
      step();
    end
    memAck = 0;
    missTxn(32'h0000_0467, 2'b11, 1'b0, 22'h0, 1, 1'b1, st, fl, wa, aa, rf);
    chk("fillAckStalls", st, 4);
    chk("fillAckFills", fl, 1);
    chk("fillAckAlloc", aa, 32'h0000_0460);
    @(negedge clk);
    chk("fillAckReqAfter", memReq, 0);
    chk("bothMissCnt", missCnt, 3);
    chk("bothStallCnt", stallCnt, 19);
    step();

    // 5: reset while ALLOC request is outstanding
    memRead = 1; hit = 0; dirty = 0; addr = 32'h0000_3000;
    step();
    addr = 32'h0000_5555;
    chk("allocReqUp", memReq, 1);
    step();
    #2;
    rstN = 1'b0; memRead = 0;
    #1;
    chk("rstMidReq", memReq, 0);
    chk("rstMidStall", stall, 0);
    chk("rstMidFill", fill, 0);
    chk("rstMidMissCnt", missCnt, 0);
    chk("rstMidStallCnt", stallCnt, 0);
    step();
    rstN = 1'b1;
    memRead = 1; hit = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("postRstHitStall", stall, 0);
      step();
    end
    memRead = 0; hit = 0;

    // 6: counter saturation on the 4-bit build
    rstN = 1'b0;
    step();
    rstN = 1'b1;
    step();
    for (int i = 0; i < 20; i++) begin
      missTxn(32'h0001_0000 + 32'(i) * 32'h20, 2'b01, 1'b0, 22'h0, 1, 1'b0, st, fl, wa, aa, rf);
      if (i == 2) begin
        chk("satMiss4Early", missCnt4, 3);
        chk("satStall4Early", stallCnt4, 12);
      end
    end
    chk("satMiss4", missCnt4, 15);
    chk("satStall4", stallCnt4, 15);
    chk("satMiss32", missCnt, 20);
    chk("satStall32", stallCnt, 80);

    $display("test done: total=%0d bad=%0d", totalNum, badNum);
    $finish;
  end
endmodule
